req_ack_packet_fifo: RTL and testbench
======================================

// Module: req_ack_packet_fifo
// PURPOSE
//  Parametrised inter-node link buffer for the MIMD mesh: N-deep FIFO between a node's 4-phase M_Req/M_Ack/M_Data
//  transmit port and a neighbour's S_Req/S_Ack/S_Data receive port. Generalises the single-slot packet buffer:
//  configurable data width, depth and input synchronisers, plus occupancy/full/empty status, so two soc nodes can
//  stream packets without lock-step stalls.
// PARAMETERS
//  DATA_WIDTH   32  packet word width (bits)
//  DEPTH        4   FIFO entries; power of 2, >= 2
//  SYNC_STAGES  0   flops on S_Req and M_Ack before use (0 = same-clock neighbours, 2 = asynchronous neighbours)
// PORTS
//  Clock     in   1              single clock, rising edge
//  nReset    in   1              asynchronous, active-low reset
//  S_Req     in   1              upstream request (4-phase)
//  S_Data    in   DATA_WIDTH     upstream data, stable while S_Req high
//  S_Ack     out  1              upstream acknowledge
//  M_Req     out  1              downstream request (4-phase)
//  M_Data    out  DATA_WIDTH     downstream data = FIFO head, stable while M_Req high
//  M_Ack     in   1              downstream acknowledge
//  Count     out  $clog2(DEPTH+1) entries held
//  Full      out  1              Count == DEPTH
//  Empty     out  1              Count == 0
// BEHAVIOUR
//  Reset (nReset low, asynchronous): S_Ack=0, M_Req=0, M_Data=0, Count=0, Empty=1, Full=0, pointers=0, both FSMs idle;
//   synchroniser flops cleared. Reset mid-handshake discards all contents; the upstream sees S_Ack drop and must
//   restart; the downstream sees M_Req drop.
//  S_Req_s / M_Ack_s = S_Req / M_Ack delayed by SYNC_STAGES flops (wire when 0). All latencies below add SYNC_STAGES.
//  Receive FSM (RX_IDLE, RX_ACK):
//   RX_IDLE: S_Req_s=1 and !Full at edge -> write S_Data to mem[wr_ptr], wr_ptr++, S_Ack=1 next cycle, go RX_ACK.
//            S_Req_s=1 and Full -> stay, S_Ack=0; request held pending until space frees (no drop, no overwrite).
//   RX_ACK:  S_Ack held 1 until S_Req_s=0 -> S_Ack=0, go RX_IDLE. One word is accepted per full 4-phase cycle.
//  Transmit FSM (TX_IDLE, TX_REQ, TX_WAIT):
//   TX_IDLE: !Empty at edge -> M_Data<=mem[rd_ptr], M_Req=1 next cycle, go TX_REQ.
//   TX_REQ:  M_Req=1, M_Data held; on M_Ack_s=1 -> rd_ptr++ (pop), M_Req=0, go TX_WAIT.
//   TX_WAIT: M_Req=0; on M_Ack_s=0 -> TX_IDLE. M_Data keeps last value until next load.
//  Fall-through: word written at edge k -> M_Req high after edge k+1 (SYNC_STAGES=0, FIFO previously empty).
//  Count: +1 on write, -1 on pop, unchanged when both occur in the same edge; Full/Empty are registered and
//   consistent with Count in every cycle. Read and write pointers are $clog2(DEPTH) bits and wrap at DEPTH.
//  Full is evaluated before the same-edge pop: a write is refused on the edge a pop frees space, and accepted next edge.
//  Data order strictly preserved; no word duplicated or lost across pointer wrap-around.
//  Protocol violations (S_Data change while S_Req high, M_Ack without M_Req) are not detected; behaviour undefined.
// TESTING
//  1 Reset: nReset=0 mid-operation -> all outputs 0, Empty=1, Count=0 asynchronously, before the next clock edge.
//  2 Single word, SYNC_STAGES=0: S_Req=1, S_Data=32'h7 -> S_Ack=1 one edge later, Count=1; M_Req=1 after next edge,
//    M_Data=7; M_Ack=1 -> M_Req=0, Count=0; M_Ack=0 -> TX_IDLE.
//  3 Fill, DEPTH=4: send 7,8,9,10 with M_Ack held 0 -> Count=4, Full=1; 5th S_Req gets no S_Ack; one pop with
//    M_Data=7 -> 5th word (11) accepted on the following edge; drain yields 8,9,10,11 in order.
//  4 Wrap: stream 1..16 through DEPTH=4 with random M_Ack delays of 0-5 cycles -> output sequence 1..16 exact,
//    Count never exceeds 4 and never underflows.
//  5 Simultaneous push/pop at Count=2 on the same edge -> Count stays 2, Full=0, Empty=0.
//  6 SYNC_STAGES=2: repeat test 2 -> S_Ack and M_Req each rise 2 cycles later than at SYNC_STAGES=0, with identical data.

Source files
------------

// File: rtl/req_ack_packet_fifo.sv
// Inter-node link buffer: DEPTH-entry FIFO between a 4-phase S_Req/S_Ack receive port
// and a 4-phase M_Req/M_Ack transmit port, with optional input synchronisers.
module req_ack_packet_fifo #(
  parameter int unsigned DATA_WIDTH  = 32,
  parameter int unsigned DEPTH       = 4,
  parameter int unsigned SYNC_STAGES = 0
) (
  input  logic                         Clock,
  input  logic                         nReset,
  input  logic                         S_Req,
  input  logic [DATA_WIDTH-1:0]        S_Data,
  output logic                         S_Ack,
  output logic                         M_Req,
  output logic [DATA_WIDTH-1:0]        M_Data,
  input  logic                         M_Ack,
  output logic [$clog2(DEPTH+1)-1:0]   Count,
  output logic                         Full,
  output logic                         Empty
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = $clog2(DEPTH+1);

  typedef enum logic {RX_IDLE, RX_ACK} rx_state_t;
  typedef enum logic [1:0] {TX_IDLE, TX_REQ, TX_WAIT} tx_state_t;

  rx_state_t             rx_state;
  tx_state_t             tx_state;
  logic                  s_req_s;
  logic                  m_ack_s;
  logic [AW-1:0]         wr_ptr;
  logic [AW-1:0]         rd_ptr;
  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic                  wr_en;
  logic                  pop;
  logic [CW-1:0]         count_next;

  generate
    if (SYNC_STAGES == 0) begin : g_nosync
      assign s_req_s = S_Req;
      assign m_ack_s = M_Ack;
    end else begin : g_sync
      logic [SYNC_STAGES-1:0] s_req_q;
      logic [SYNC_STAGES-1:0] m_ack_q;
      always_ff @(posedge Clock or negedge nReset) begin
        if (!nReset) begin
          s_req_q <= '0;
          m_ack_q <= '0;
        end else begin
          s_req_q[0] <= S_Req;
          m_ack_q[0] <= M_Ack;
          for (int unsigned i = 1; i < SYNC_STAGES; i++) begin
            s_req_q[i] <= s_req_q[i-1];
            m_ack_q[i] <= m_ack_q[i-1];
          end
        end
      end
      assign s_req_s = s_req_q[SYNC_STAGES-1];
      assign m_ack_s = m_ack_q[SYNC_STAGES-1];
    end
  endgenerate

  // Full is the registered flag, so a pop on the same edge does not make room yet.
  always_comb begin
    wr_en      = (rx_state == RX_IDLE) && s_req_s && !Full;
    pop        = (tx_state == TX_REQ) && m_ack_s;
    count_next = Count;
    if (wr_en && !pop)
      count_next = Count + CW'(1);
    else if (!wr_en && pop)
      count_next = Count - CW'(1);
  end

  always_ff @(posedge Clock) begin
    if (wr_en)
      mem[wr_ptr] <= S_Data;
  end

  always_ff @(posedge Clock or negedge nReset) begin
    if (!nReset) begin
      rx_state <= RX_IDLE;
      S_Ack    <= 1'b0;
      wr_ptr   <= '0;
    end else begin
      case (rx_state)
        RX_IDLE: begin
          if (wr_en) begin
            wr_ptr   <= wr_ptr + AW'(1);
            S_Ack    <= 1'b1;
            rx_state <= RX_ACK;
          end
        end
        RX_ACK: begin
          if (!s_req_s) begin
            S_Ack    <= 1'b0;
            rx_state <= RX_IDLE;
          end
        end
        default: begin
          S_Ack    <= 1'b0;
          rx_state <= RX_IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge Clock or negedge nReset) begin
    if (!nReset) begin
      tx_state <= TX_IDLE;
      M_Req    <= 1'b0;
      M_Data   <= '0;
      rd_ptr   <= '0;
    end else begin
      case (tx_state)
        TX_IDLE: begin
          if (!Empty) begin
            M_Data   <= mem[rd_ptr];
            M_Req    <= 1'b1;
            tx_state <= TX_REQ;
          end
        end
        TX_REQ: begin
          if (m_ack_s) begin
            rd_ptr   <= rd_ptr + AW'(1);
            M_Req    <= 1'b0;
            tx_state <= TX_WAIT;
          end
        end
        TX_WAIT: begin
          if (!m_ack_s)
            tx_state <= TX_IDLE;
        end
        default: begin
          M_Req    <= 1'b0;
          tx_state <= TX_IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge Clock or negedge nReset) begin
    if (!nReset) begin
      Count <= '0;
      Full  <= 1'b0;
      Empty <= 1'b1;
    end else begin
      Count <= count_next;
      Full  <= (count_next == CW'(DEPTH));
      Empty <= (count_next == '0);
    end
  end

endmodule

// File: tb/tb_req_ack_packet_fifo.sv
// Directed bench for req_ack_packet_fifo: one instance with same-clock inputs,
// one with two-stage input synchronisers.
module tb_req_ack_packet_fifo;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;

  logic        s_req0 = 1'b0, m_ack0 = 1'b0;
  logic [31:0] s_data0 = '0;
  logic        s_ack0, m_req0, full0, empty0;
  logic [31:0] m_data0;
  logic [2:0]  count0;

  logic        s_req2 = 1'b0, m_ack2 = 1'b0;
  logic [31:0] s_data2 = '0;
  logic        s_ack2, m_req2, full2, empty2;
  logic [31:0] m_data2;
  logic [2:0]  count2;

  int tests = 0;
  int fails = 0;
  int max_count = 0;

  always #5 clk = ~clk;

  req_ack_packet_fifo #(.DATA_WIDTH(32), .DEPTH(4), .SYNC_STAGES(0)) dut0 (
    .Clock(clk), .nReset(rst_n), .S_Req(s_req0), .S_Data(s_data0), .S_Ack(s_ack0),
    .M_Req(m_req0), .M_Data(m_data0), .M_Ack(m_ack0), .Count(count0), .Full(full0), .Empty(empty0)
  );

  req_ack_packet_fifo #(.DATA_WIDTH(32), .DEPTH(4), .SYNC_STAGES(2)) dut2 (
    .Clock(clk), .nReset(rst_n), .S_Req(s_req2), .S_Data(s_data2), .S_Ack(s_ack2),
    .M_Req(m_req2), .M_Data(m_data2), .M_Ack(m_ack2), .Count(count2), .Full(full2), .Empty(empty2)
  );

  always @(negedge clk) begin
    if (rst_n && int'(count0) > max_count)
      max_count = int'(count0);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_s_ack0(input logic v, input string tag);
    for (int n = 0; n < 60; n++) begin
      if (s_ack0 === v) break;
      tick();
    end
    chk(tag, {31'd0, s_ack0}, {31'd0, v});
  endtask

  task automatic wait_m_req0(input logic v, input string tag);
    for (int n = 0; n < 60; n++) begin
      if (m_req0 === v) break;
      tick();
    end
    chk(tag, {31'd0, m_req0}, {31'd0, v});
  endtask

  task automatic send0(input logic [31:0] d);
    s_req0  = 1'b1;
    s_data0 = d;
    wait_s_ack0(1'b1, "send_ack_rise");
    s_req0 = 1'b0;
    wait_s_ack0(1'b0, "send_ack_fall");
  endtask

  task automatic recv0(input int delay, output logic [31:0] d);
    wait_m_req0(1'b1, "recv_req_rise");
    d = m_data0;
    repeat (delay) tick();
    m_ack0 = 1'b1;
    wait_m_req0(1'b0, "recv_req_fall");
    m_ack0 = 1'b0;
  endtask

  initial begin
    logic [31:0] d;

    // Reset state
    tick(); tick();
    chk("rst_s_ack", {31'd0, s_ack0}, 32'd0);
    chk("rst_m_req", {31'd0, m_req0}, 32'd0);
    chk("rst_m_data", m_data0, 32'd0);
    chk("rst_count", {29'd0, count0}, 32'd0);
    chk("rst_empty", {31'd0, empty0}, 32'd1);
    chk("rst_full", {31'd0, full0}, 32'd0);
    rst_n = 1'b1;
    tick();

    // Single word, same-clock
    s_req0 = 1'b1; s_data0 = 32'h7;
    tick();
    chk("single_s_ack", {31'd0, s_ack0}, 32'd1);
    chk("single_count1", {29'd0, count0}, 32'd1);
    chk("single_m_req_early", {31'd0, m_req0}, 32'd0);
    tick();
    chk("single_m_req", {31'd0, m_req0}, 32'd1);
    chk("single_m_data", m_data0, 32'h7);
    s_req0 = 1'b0; m_ack0 = 1'b1;
    tick();
    chk("single_m_req_drop", {31'd0, m_req0}, 32'd0);
    chk("single_count0", {29'd0, count0}, 32'd0);
    chk("single_empty", {31'd0, empty0}, 32'd1);
    chk("single_s_ack_drop", {31'd0, s_ack0}, 32'd0);
    m_ack0 = 1'b0;
    tick(); tick();

    // Single word through two-stage synchronisers: everything two edges later
    s_req2 = 1'b1; s_data2 = 32'h7;
    tick();
    chk("sync2_s_ack_e1", {31'd0, s_ack2}, 32'd0);
    tick();
    chk("sync2_s_ack_e2", {31'd0, s_ack2}, 32'd0);
    tick();
    chk("sync2_s_ack_e3", {31'd0, s_ack2}, 32'd1);
    chk("sync2_m_req_e3", {31'd0, m_req2}, 32'd0);
    tick();
    chk("sync2_m_req_e4", {31'd0, m_req2}, 32'd1);
    chk("sync2_m_data", m_data2, 32'h7);
    s_req2 = 1'b0; m_ack2 = 1'b1;
    tick(); tick();
    chk("sync2_m_req_hold", {31'd0, m_req2}, 32'd1);
    tick();
    chk("sync2_m_req_drop", {31'd0, m_req2}, 32'd0);
    chk("sync2_count0", {29'd0, count2}, 32'd0);
    chk("sync2_s_ack_drop", {31'd0, s_ack2}, 32'd0);
    m_ack2 = 1'b0;
    tick(); tick(); tick(); tick();

    // Fill to DEPTH, refuse a fifth word until a pop frees space
    send0(32'd7); send0(32'd8); send0(32'd9); send0(32'd10);
    chk("fill_count", {29'd0, count0}, 32'd4);
    chk("fill_full", {31'd0, full0}, 32'd1);
    chk("fill_head", m_data0, 32'd7);
    chk("fill_m_req", {31'd0, m_req0}, 32'd1);
    s_req0 = 1'b1; s_data0 = 32'd11;
    tick(); tick(); tick();
    chk("full_no_ack", {31'd0, s_ack0}, 32'd0);
    chk("full_count_hold", {29'd0, count0}, 32'd4);
    m_ack0 = 1'b1;
    tick();
    chk("pop_edge_refused", {31'd0, s_ack0}, 32'd0);
    chk("pop_edge_count", {29'd0, count0}, 32'd3);
    chk("pop_edge_full", {31'd0, full0}, 32'd0);
    tick();
    chk("pending_accepted", {31'd0, s_ack0}, 32'd1);
    chk("pending_count", {29'd0, count0}, 32'd4);
    s_req0 = 1'b0; m_ack0 = 1'b0;
    wait_s_ack0(1'b0, "pending_release");
    for (int i = 8; i <= 11; i++) begin
      recv0(0, d);
      chk("drain_data", d, 32'(i));
    end
    chk("drain_count", {29'd0, count0}, 32'd0);
    chk("drain_empty", {31'd0, empty0}, 32'd1);
    tick(); tick();

    // Stream 1..16 across pointer wrap with random acknowledge delays
    max_count = 0;
    fork
      begin
        for (int i = 1; i <= 16; i++) send0(32'(i));
      end
      begin
        logic [31:0] w;
        for (int j = 1; j <= 16; j++) begin
          recv0(int'($urandom_range(0, 5)), w);
          chk("wrap_data", w, 32'(j));
        end
      end
    join
    chk("wrap_max_count", {31'd0, (max_count <= 4)}, 32'd1);
    chk("wrap_final_count", {29'd0, count0}, 32'd0);
    tick(); tick();

    // Simultaneous push and pop at Count=2
    send0(32'd20); send0(32'd21);
    wait_m_req0(1'b1, "simul_req");
    chk("simul_pre_count", {29'd0, count0}, 32'd2);
    s_req0 = 1'b1; s_data0 = 32'd22; m_ack0 = 1'b1;
    tick();
    chk("simul_count", {29'd0, count0}, 32'd2);
    chk("simul_full", {31'd0, full0}, 32'd0);
    chk("simul_empty", {31'd0, empty0}, 32'd0);
    chk("simul_s_ack", {31'd0, s_ack0}, 32'd1);
    chk("simul_m_req", {31'd0, m_req0}, 32'd0);
    s_req0 = 1'b0; m_ack0 = 1'b0;
    wait_s_ack0(1'b0, "simul_release");
    recv0(1, d); chk("simul_drain0", d, 32'd21);
    recv0(0, d); chk("simul_drain1", d, 32'd22);
    tick(); tick();

    // Asynchronous reset in the middle of a transfer
    send0(32'h33);
    wait_m_req0(1'b1, "midrst_req");
    #3;
    rst_n = 1'b0;
    #1;
    chk("midrst_s_ack", {31'd0, s_ack0}, 32'd0);
    chk("midrst_m_req", {31'd0, m_req0}, 32'd0);
    chk("midrst_m_data", m_data0, 32'd0);
    chk("midrst_count", {29'd0, count0}, 32'd0);
    chk("midrst_empty", {31'd0, empty0}, 32'd1);
    chk("midrst_full", {31'd0, full0}, 32'd0);
    tick();
    rst_n = 1'b1;
    tick(); tick();
    chk("post_rst_m_req", {31'd0, m_req0}, 32'd0);
    chk("post_rst_empty", {31'd0, empty0}, 32'd1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
